compa_sched: RTL and testbench

- Round-robin scheduler that shares one 8-bit sign-magnitude comparator among NREQ requesters.
- Each requester presents an operand pair with valid/ready handshake. The block grants one requester, performs the comparison, and returns a tagged 2-bit result on a single response port with valid/ready handshake.
- Sits between requesting datapath units and the shared compare resource.

---
 rtl/compa_sched.sv | 176 +++++++++++++++++
 tb/tb_compa_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/compa_sched.sv
// Round-robin scheduler sharing one 8-bit sign-magnitude comparator among NREQ requesters.
// Define COMPA_SCHED_STATS_EN to add saturating per-result counters (stat_gt/stat_lt/stat_eq, cleared by stat_clr).
module compa_sched #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [1:0]        rsp_out
`ifdef COMPA_SCHED_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_gt,
    output logic [15:0]       stat_lt,
    output logic [15:0]       stat_eq
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CMP  = 2'b01,
        RSP  = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [ID_W-1:0] ptr_r;
    logic [ID_W-1:0] cap_id_r;
    logic [7:0]      cap_a_r;
    logic [7:0]      cap_b_r;
    logic [ID_W-1:0] scan_id_s;
    logic [ID_W-1:0] grant_idx_s;
    logic            grant_found_s;

    // Sign-magnitude compare; +0 and -0 are equal, so the result is always one of 10/01/00.
    function automatic logic [1:0] sm_compare(input logic [7:0] a, input logic [7:0] b);
        logic [1:0] res;
        if ((a[6:0] == 7'd0) && (b[6:0] == 7'd0)) begin
            res = 2'b00;
        end else if (a[7] != b[7]) begin
            res = a[7] ? 2'b01 : 2'b10;
        end else if (a[6:0] == b[6:0]) begin
            res = 2'b00;
        end else if (a[7] == 1'b0) begin
            res = (a[6:0] > b[6:0]) ? 2'b10 : 2'b01;
        end else begin
            res = (a[6:0] < b[6:0]) ? 2'b10 : 2'b01;
        end
        return res;
    endfunction

    // First valid requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {ID_W{1'b0}};
        scan_id_s     = {ID_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            scan_id_s = ID_W'((int'(ptr_r) + k) % NREQ);
            if (!grant_found_s && req_valid[scan_id_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = scan_id_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and the Mealy grant, which is only offered while idle.
    always_comb begin
        state_nxt_s = state_r;
        req_ready   = {NREQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (grant_found_s) begin
                    state_nxt_s = CMP;
                    req_ready   = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CMP: begin
                state_nxt_s = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RSP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand capture, result register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_a_r   <= 8'h00;
            cap_b_r   <= 8'h00;
            cap_id_r  <= {ID_W{1'b0}};
            ptr_r     <= {ID_W{1'b0}};
            rsp_valid <= 1'b0;
            rsp_id    <= {ID_W{1'b0}};
            rsp_out   <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_found_s) begin
                        cap_a_r  <= req_a[{grant_idx_s, 3'b000} +: 8];
                        cap_b_r  <= req_b[{grant_idx_s, 3'b000} +: 8];
                        cap_id_r <= grant_idx_s;
                    end
                end
                CMP: begin
                    rsp_out   <= sm_compare(cap_a_r, cap_b_r);
                    rsp_id    <= cap_id_r;
                    rsp_valid <= 1'b1;
                end
                RSP: begin
                    // The pointer moves only when a response completes, so skipped requesters keep their turn.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr_r     <= (rsp_id == ID_W'(NREQ - 1)) ? {ID_W{1'b0}} : (rsp_id + ID_W'(1));
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef COMPA_SCHED_STATS_EN
    logic rsp_hs_s;
    assign rsp_hs_s = rsp_valid && rsp_ready;

    // Saturating result counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_gt <= 16'h0000;
            stat_lt <= 16'h0000;
            stat_eq <= 16'h0000;
        end else if (stat_clr) begin
            stat_gt <= 16'h0000;
            stat_lt <= 16'h0000;
            stat_eq <= 16'h0000;
        end else if (rsp_hs_s) begin
            case (rsp_out)
                2'b10: if (stat_gt != 16'hFFFF) stat_gt <= stat_gt + 16'd1;
                2'b01: if (stat_lt != 16'hFFFF) stat_lt <= stat_lt + 16'd1;
                2'b00: if (stat_eq != 16'hFFFF) stat_eq <= stat_eq + 16'd1;
                default: stat_eq <= stat_eq;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_compa_sched.sv
// Bench for compa_sched: directed cases and randomized traffic checked against a
// transaction-level model (signed-integer compare, first-valid-from-pointer arbitration).
module tb_compa_sched;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_a = '0;
    logic [8*NREQ-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [ID_W-1:0]   rsp_id;
    logic [1:0]        rsp_out;
`ifdef COMPA_SCHED_STATS_EN
    logic              stat_clr = 1'b0;
    logic [15:0]       stat_gt;
    logic [15:0]       stat_lt;
    logic [15:0]       stat_eq;
`endif

    compa_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out)
`ifdef COMPA_SCHED_STATS_EN
        , .stat_clr(stat_clr), .stat_gt(stat_gt), .stat_lt(stat_lt), .stat_eq(stat_eq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    // Model: m_phase -1 = free, 0 = comparing, 1 = response offered.
    int m_phase = -1;
    int m_ptr = 0;
    int m_id = 0;
    logic [1:0] m_res = 2'b00;
    int m_gt = 0, m_lt = 0, m_eq = 0;
    logic [1:0] seen_out;
    int hs_ids[$];
    logic [1:0] hs_outs[$];
    int grant_cycles[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_cmp(input logic [7:0] a, input logic [7:0] b);
        int va, vb;
        va = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
        vb = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
        if (va > vb) return 2'b10;
        if (va < vb) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ] === 1'b1) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [7:0] rnd_byte();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h80;
            2: return 8'h7F;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic check_outputs();
        int g;
        logic [NREQ-1:0] er;
        g  = pick(req_valid, m_ptr);
        er = '0;
        if (m_phase < 0 && g >= 0) er = NREQ'(1) << g;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), (m_phase == 1) ? 32'd1 : 32'd0);
        if (m_phase == 1) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_out", 32'(rsp_out), 32'(m_res));
        end
        seen_out = rsp_out;
`ifdef COMPA_SCHED_STATS_EN
        chk("stat_gt", 32'(stat_gt), 32'(m_gt));
        chk("stat_lt", 32'(stat_lt), 32'(m_lt));
        chk("stat_eq", 32'(stat_eq), 32'(m_eq));
`endif
    endtask

    task automatic model_update();
        int g;
        g = pick(req_valid, m_ptr);
`ifdef COMPA_SCHED_STATS_EN
        if (stat_clr) begin
            m_gt = 0; m_lt = 0; m_eq = 0;
        end else if (m_phase == 1 && rsp_ready) begin
            if (m_res == 2'b10 && m_gt < 65535) m_gt++;
            if (m_res == 2'b01 && m_lt < 65535) m_lt++;
            if (m_res == 2'b00 && m_eq < 65535) m_eq++;
        end
`endif
        if (m_phase < 0) begin
            if (g >= 0) begin
                m_phase = 0;
                m_id    = g;
                m_res   = ref_cmp(req_a[8*g +: 8], req_b[8*g +: 8]);
                grant_cycles.push_back(cyc);
            end
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (rsp_ready) begin
            hs_ids.push_back(m_id);
            hs_outs.push_back(seen_out);
            m_ptr   = (m_id + 1) % NREQ;
            m_phase = -1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        m_phase = -1; m_ptr = 0; m_gt = 0; m_lt = 0; m_eq = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] exp, input string tag);
        int n0;
        n0 = hs_outs.size();
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        cycle();
        req_valid = '0;
        req_a = $urandom;
        req_b = $urandom;
        repeat (3) cycle();
        chk({tag, "_count"}, 32'(hs_outs.size()), 32'(n0 + 1));
        if (hs_outs.size() > n0) chk(tag, 32'(hs_outs[$]), 32'(exp));
    endtask

    initial begin
        #2;
        do_reset();
        repeat (2) cycle();

        // Single requester, negative vs positive operand.
        rsp_ready = 1'b1;
        run_one(0, 8'h85, 8'h03, 2'b01, "neg_vs_pos");
        run_one(2, 8'h07, 8'h05, 2'b10, "pos_mag");
        run_one(2, 8'h87, 8'h85, 2'b01, "neg_mag");
        run_one(2, 8'h80, 8'h00, 2'b00, "zero_eq");
        run_one(2, 8'h7F, 8'hFF, 2'b10, "pos_max");

        // All requesters held valid from reset.
        do_reset();
        hs_ids.delete();
        grant_cycles.delete();
        req_valid = 4'hF;
        for (int i = 0; i < 15; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                req_a[8*r +: 8] = rnd_byte();
                req_b[8*r +: 8] = rnd_byte();
            end
            cycle();
        end
        chk("rr_count", 32'(hs_ids.size()), 32'd5);
        for (int i = 0; i < hs_ids.size() && i < 5; i++) chk("rr_order", 32'(hs_ids[i]), 32'(i % NREQ));
        for (int i = 1; i < grant_cycles.size() && i < 5; i++)
            chk("rr_spacing", 32'(grant_cycles[i] - grant_cycles[i-1]), 32'd3);

        // Backpressure on requester 3 with others waiting.
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        cycle();
        req_valid = 4'b0101;
        repeat (6) cycle();
        rsp_ready = 1'b1;
        cycle();
        cycle();
        req_valid = '0;
        repeat (3) cycle();

        // Reset while a response is pending.
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        repeat (3) cycle();
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b1001;
        cycle();
        req_valid = '0;
        repeat (4) cycle();

`ifdef COMPA_SCHED_STATS_EN
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        run_one(2, 8'h07, 8'h05, 2'b10, "st_gt1");
        run_one(2, 8'h7F, 8'hFF, 2'b10, "st_gt2");
        run_one(2, 8'h80, 8'h00, 2'b00, "st_eq");
        chk("stat_gt_2", 32'(stat_gt), 32'd2);
        chk("stat_eq_1", 32'(stat_eq), 32'd1);
        chk("stat_lt_0", 32'(stat_lt), 32'd0);
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        chk("clr_gt", 32'(stat_gt), 32'd0);
        chk("clr_eq", 32'(stat_eq), 32'd0);
`endif

        // Randomized traffic with random backpressure and operand churn.
        for (int i = 0; i < 400; i++) begin
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
            for (int r = 0; r < NREQ; r++) begin
                req_a[8*r +: 8] = rnd_byte();
                req_b[8*r +: 8] = rnd_byte();
            end
`ifdef COMPA_SCHED_STATS_EN
            stat_clr = ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0;
`endif
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
